pipeline_register: RTL

PIPELINE_REGISTER -- requirements
Module: pipeline_register

---
 rtl/pipeline_register_pkg.sv | 6 +
 rtl/pipeline_register_pipe_stage.sv | 34 +++
 rtl/pipeline_register.sv | 73 +++++++
 3 files changed

// File: rtl/pipeline_register_pkg.sv
// Shared core constants for the pipeline register slice.
package pipeline_register_pkg;

    localparam int XLEN = 32;

endpackage

// File: rtl/pipeline_register_pipe_stage.sv
// One pipeline stage: a valid bit plus a payload word, with load enable and clear.
module pipe_stage
    import pipeline_register_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic             src_valid,
    input  logic [WIDTH-1:0] src_data,
    output logic             valid,
    output logic [WIDTH-1:0] data
);

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
        end else begin
            if (clr) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= src_valid;
            end
            // Payload only moves with a real item, so empty slots keep their last word.
            if (load && src_valid) begin
                data <= src_data;
            end
        end
    end

endmodule

// File: rtl/pipeline_register.sv
// Elastic DEPTH-stage register pipeline with bubble collapsing, flush and occupancy count.
module pipeline_register
    import pipeline_register_pkg::*;
#(
    parameter int WIDTH = XLEN,
    parameter int DEPTH = 2,
    localparam int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH:0]   adv;
    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] src_v;
    logic [WIDTH-1:0] src_d [DEPTH];
    logic             accept;

    // A stage advances when it is empty or everything downstream of it advances.
    always_comb begin
        adv        = '0;
        adv[DEPTH] = out_ready;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            adv[i] = !v[i] || adv[i+1];
        end
    end

    assign in_ready = adv[0] && !flush;
    assign accept   = in_valid && in_ready;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign src_v[gi] = accept;
            assign src_d[gi] = in_data;
        end else begin : g_body
            assign src_v[gi] = v[gi-1];
            assign src_d[gi] = d[gi-1];
        end

        pipe_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .rst      (rst),
            .clr      (flush),
            .load     (adv[gi]),
            .src_valid(src_v[gi]),
            .src_data (src_d[gi]),
            .valid    (v[gi]),
            .data     (d[gi])
        );
    end

    always_comb begin
        occupancy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            occupancy = occupancy + OCC_W'(v[i]);
        end
    end

    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];

endmodule
